// File: rtl/moving_average_param.sv
// moving_average_param: running mean over a run-time selectable 2^k sample window with warm-up, flush and optional rounding.
module moving_average_param #(
   parameter int DATA_W     = 8,
   parameter int LOG2_DEPTH = 3,
   parameter int ROUND      = 0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               ena,
   input  logic                               in_valid,
   input  logic [DATA_W-1:0]                  in_data,
   input  logic [$clog2(LOG2_DEPTH+1)-1:0]    win_sel,
   input  logic                               clear,
   output logic                               out_valid,
   output logic [DATA_W-1:0]                  out_data,
   output logic                               full
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int AW    = DATA_W + LOG2_DEPTH;
   localparam int CW    = LOG2_DEPTH + 1;
   localparam int KW    = $clog2(LOG2_DEPTH + 1);

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [AW-1:0]         acc, base_acc, acc_next, half;
   logic [CW-1:0]         count, base_cnt, cnt_next, n;
   logic [LOG2_DEPTH-1:0] wr_ptr, base_ptr, rd_ptr;
   logic [KW-1:0]         active_k, k_sel, k_now;
   logic [DATA_W-1:0]     oldest, avg;
   logic                  flush, accept;

   // A flush (clear or window change) is applied before the sample of the same cycle.
   always_comb begin
      k_sel    = (win_sel > KW'(LOG2_DEPTH)) ? KW'(LOG2_DEPTH) : win_sel;
      flush    = ena && (clear || k_sel != active_k);
      accept   = ena && in_valid;
      k_now    = ena ? k_sel : active_k;
      base_acc = flush ? '0 : acc;
      base_cnt = flush ? '0 : count;
      base_ptr = flush ? '0 : wr_ptr;
      n        = CW'(1) << k_now;
      rd_ptr   = base_ptr - n[LOG2_DEPTH-1:0];
      oldest   = (base_cnt >= n) ? mem[rd_ptr] : '0;
      acc_next = base_acc + AW'(in_data) - AW'(oldest);
      cnt_next = base_cnt + CW'(base_cnt != CW'(DEPTH));
      half     = (ROUND != 0 && k_now != '0) ? AW'(1) << (k_now - KW'(1)) : '0;
      avg      = DATA_W'((acc_next + half) >> k_now);
   end

   always_ff @(posedge clk)
      if (accept) mem[base_ptr] <= in_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         full      <= 1'b0;
         acc       <= '0;
         count     <= '0;
         wr_ptr    <= '0;
         active_k  <= '0;
      end else if (ena) begin
         out_valid <= in_valid;
         if (flush) active_k <= k_sel;
         if (in_valid) begin
            acc      <= acc_next;
            count    <= cnt_next;
            wr_ptr   <= base_ptr + 1'b1;
            out_data <= avg;
            full     <= cnt_next >= n;
         end else if (flush) begin
            acc    <= '0;
            count  <= '0;
            wr_ptr <= '0;
            full   <= 1'b0;
         end
      end else begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_moving_average_param.sv
// tb_moving_average_param: directed checks of the moving average, truncating and rounding variants side by side.
module tb_moving_average_param;
   localparam int DW = 8;
   localparam int L  = 3;
   localparam int KW = $clog2(L + 1);

   logic          clk = 1'b0, rst_n = 1'b0, ena = 1'b1, in_valid = 1'b0, clear = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [KW-1:0] win_sel = KW'(2);
   logic          ov, ovr, fl, flr;
   logic [DW-1:0] od, odr;
   int            tests = 0, fails = 0;

   always #5 clk = ~clk;

   moving_average_param #(.DATA_W(DW), .LOG2_DEPTH(L), .ROUND(0)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
      .win_sel(win_sel), .clear(clear), .out_valid(ov), .out_data(od), .full(fl));

   moving_average_param #(.DATA_W(DW), .LOG2_DEPTH(L), .ROUND(1)) dut_r (
      .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
      .win_sel(win_sel), .clear(clear), .out_valid(ovr), .out_data(odr), .full(flr));

   task automatic send(input logic [DW-1:0] x);
      in_valid = 1'b1;
      in_data  = x;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", ov); end
      tests++; if (od !== 8'd0) begin fails++; $display("FAIL reset_data got %0d want 0", od); end
      tests++; if (fl !== 1'b0) begin fails++; $display("FAIL reset_full got %0b want 0", fl); end
      rst_n = 1'b1;
      win_sel = KW'(2);
      for (int i = 0; i < 5; i++) send(8'd100);
      tests++; if (od !== 8'd100 || fl !== 1'b1) begin fails++; $display("FAIL pre_reset got %0d/%0b want 100/1", od, fl); end
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (ov !== 1'b0 || od !== 8'd0 || fl !== 1'b0) begin fails++; $display("FAIL async_reset got %0b/%0d/%0b want 0/0/0", ov, od, fl); end
      rst_n = 1'b1;
      send(8'd40);
      tests++; if (ov !== 1'b1 || od !== 8'd10 || fl !== 1'b0) begin fails++; $display("FAIL post_reset got %0b/%0d/%0b want 1/10/0", ov, od, fl); end
   endtask

   task automatic test_constant();
      logic [DW-1:0] e;
      do_reset();
      win_sel = KW'(2);
      for (int i = 1; i <= 6; i++) begin
         send(8'd100);
         e = DW'((i > 4 ? 4 : i) * 25);
         tests++; if (ov !== 1'b1) begin fails++; $display("FAIL const_valid%0d got %0b want 1", i, ov); end
         tests++; if (od !== e) begin fails++; $display("FAIL const_data%0d got %0d want %0d", i, od, e); end
         tests++; if (fl !== (i >= 4)) begin fails++; $display("FAIL const_full%0d got %0b want %0b", i, fl, i >= 4); end
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] e;
      do_reset();
      win_sel = KW'(3);
      for (int i = 1; i <= 20; i++) begin
         send(8'd255);
         e = DW'(((i > 8 ? 8 : i) * 255) >> 3);
         tests++; if (od !== e) begin fails++; $display("FAIL wrap_data%0d got %0d want %0d", i, od, e); end
         tests++; if (fl !== (i >= 8)) begin fails++; $display("FAIL wrap_full%0d got %0b want %0b", i, fl, i >= 8); end
      end
   endtask

   task automatic test_window_change();
      do_reset();
      win_sel = KW'(2);
      for (int i = 0; i < 4; i++) send(8'd100);
      tests++; if (od !== 8'd100 || fl !== 1'b1) begin fails++; $display("FAIL win_steady got %0d/%0b want 100/1", od, fl); end
      win_sel = KW'(1);
      send(8'd60);
      tests++; if (ov !== 1'b1 || od !== 8'd30 || fl !== 1'b0) begin fails++; $display("FAIL win_switch got %0b/%0d/%0b want 1/30/0", ov, od, fl); end
      send(8'd60);
      tests++; if (od !== 8'd60 || fl !== 1'b1) begin fails++; $display("FAIL win_next got %0d/%0b want 60/1", od, fl); end
      win_sel = KW'(0);
      send(8'd77);
      tests++; if (od !== 8'd77 || fl !== 1'b1) begin fails++; $display("FAIL win_k0 got %0d/%0b want 77/1", od, fl); end
   endtask

   task automatic test_clear_gaps();
      do_reset();
      win_sel = KW'(2);
      send(8'd8);
      tests++; if (ov !== 1'b1 || od !== 8'd2) begin fails++; $display("FAIL gap_first got %0b/%0d want 1/2", ov, od); end
      idle();
      tests++; if (ov !== 1'b0 || od !== 8'd2) begin fails++; $display("FAIL gap_idle got %0b/%0d want 0/2", ov, od); end
      send(8'd8);
      tests++; if (ov !== 1'b1 || od !== 8'd4) begin fails++; $display("FAIL gap_second got %0b/%0d want 1/4", ov, od); end
      clear = 1'b1;
      send(8'd8);
      tests++; if (ov !== 1'b1 || od !== 8'd2 || fl !== 1'b0) begin fails++; $display("FAIL gap_clear got %0b/%0d/%0b want 1/2/0", ov, od, fl); end
      ena = 1'b0;
      clear = 1'b1;
      win_sel = KW'(0);
      send(8'd200);
      idle();
      tests++; if (ov !== 1'b0 || od !== 8'd2) begin fails++; $display("FAIL gap_ena_low got %0b/%0d want 0/2", ov, od); end
      ena = 1'b1;
      win_sel = KW'(2);
      send(8'd8);
      tests++; if (ov !== 1'b1 || od !== 8'd4 || fl !== 1'b0) begin fails++; $display("FAIL gap_resume got %0b/%0d/%0b want 1/4/0", ov, od, fl); end
   endtask

   task automatic test_rounding();
      do_reset();
      win_sel = KW'(2);
      send(8'd1);
      tests++; if (odr !== 8'd0) begin fails++; $display("FAIL round_r1 got %0d want 0", odr); end
      tests++; if (od !== 8'd0) begin fails++; $display("FAIL round_t1 got %0d want 0", od); end
      send(8'd1);
      tests++; if (odr !== 8'd1 || ovr !== 1'b1) begin fails++; $display("FAIL round_r2 got %0d/%0b want 1/1", odr, ovr); end
      tests++; if (od !== 8'd0) begin fails++; $display("FAIL round_t2 got %0d want 0", od); end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_wrap();
      test_window_change();
      test_clear_gaps();
      test_rounding();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
